// File: rtl/lane_arbiter_if.sv
// Lane request/control bundle between the node ports and one lane_arbiter instance.
interface lane_arbiter_if #(
    parameter int unsigned NODE_COUNT       = 8,
    parameter int unsigned NODE_COUNT_DIGIT = 3
);
    localparam int unsigned REQ_W = NODE_COUNT_DIGIT + 1;

    logic [NODE_COUNT*REQ_W-1:0]  req_in;
    logic [NODE_COUNT*3-1:0]      ctrl_out;
    logic [NODE_COUNT_DIGIT-1:0]  cur_src;
    logic [NODE_COUNT_DIGIT-1:0]  cur_dst;
    logic [15:0]                  xfer_count;

    modport master (
        output req_in,
        input  ctrl_out, cur_src, cur_dst, xfer_count
    );

    modport slave (
        input  req_in,
        output ctrl_out, cur_src, cur_dst, xfer_count
    );
endinterface

// File: rtl/lane_arbiter.sv
// Round-robin arbiter for one directional lane: elects a sender, holds the lane
// for HOLD_CYCLES, then inserts one turnaround cycle.
module lane_arbiter #(
    parameter int unsigned NODE_COUNT       = 8,
    parameter int unsigned NODE_COUNT_DIGIT = 3,
    parameter int unsigned DIRECTION        = 0,
    parameter int unsigned HOLD_CYCLES      = 1,
    parameter int unsigned REQ_W            = NODE_COUNT_DIGIT + 1
) (
    input  logic           clk,
    input  logic           reset,
    lane_arbiter_if.slave  bus
);
    localparam int unsigned NW     = NODE_COUNT_DIGIT;
    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int unsigned CTRL_W = NODE_COUNT * 3;

    typedef enum logic [1:0] {IDLE, XFER, RELEASE} state_t;

    state_t             state_q, state_d;
    logic [NW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [NW-1:0]      src_q, src_d;
    logic [NW-1:0]      dst_q, dst_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
    logic [NW:0]        pick;

    // Returns {found, node}: first eligible requester at or after ptr, wrapping.
    function automatic logic [NW:0] pick_f(input logic [NODE_COUNT*REQ_W-1:0] req,
                                           input logic [NW-1:0] ptr);
        logic              found;
        logic [NW-1:0]     sel;
        logic [REQ_W-1:0]  r;
        logic              ok;
        int unsigned       idx;
        found = 1'b0;
        sel   = '0;
        for (int unsigned k = 0; k < NODE_COUNT; k++) begin
            idx = (32'(ptr) + k) % NODE_COUNT;
            r   = req[idx*REQ_W +: REQ_W];
            if (DIRECTION == 0) ok = r[REQ_W-1] && (32'(r[NW-1:0]) > idx);
            else                ok = r[REQ_W-1] && (32'(r[NW-1:0]) < idx);
            if (ok && !found) begin
                found = 1'b1;
                sel   = NW'(idx);
            end
        end
        return {found, sel};
    endfunction

    assign pick = pick_f(bus.req_in, rr_ptr_q);

    // Next-state, arbitration and next-output logic.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        hold_d   = hold_q;
        src_d    = src_q;
        dst_d    = dst_q;
        cnt_d    = cnt_q;
        ctrl_d   = '0;
        unique case (state_q)
            IDLE: begin
                if (pick[NW]) begin
                    state_d = XFER;
                    src_d   = pick[NW-1:0];
                    dst_d   = bus.req_in[32'(pick[NW-1:0])*REQ_W +: NW];
                    hold_d  = HOLD_W'(HOLD_CYCLES - 1);
                end
            end
            XFER: begin
                if (hold_q == '0) begin
                    state_d  = RELEASE;
                    cnt_d    = cnt_q + 16'd1;
                    rr_ptr_d = (src_q == NW'(NODE_COUNT - 1)) ? '0 : src_q + NW'(1);
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_d == XFER) begin
            for (int unsigned i = 0; i < NODE_COUNT; i++) begin
                ctrl_d[i*3 + 2] = (src_d == NW'(i));
                ctrl_d[i*3 + 1] = (dst_d == NW'(i));
                ctrl_d[i*3]     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            hold_q   <= '0;
            src_q    <= '0;
            dst_q    <= '0;
            cnt_q    <= '0;
            ctrl_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            hold_q   <= hold_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            cnt_q    <= cnt_d;
            ctrl_q   <= ctrl_d;
        end
    end

    assign bus.ctrl_out   = ctrl_q;
    assign bus.cur_src    = src_q;
    assign bus.cur_dst    = dst_q;
    assign bus.xfer_count = cnt_q;
endmodule

// File: tb/tb_lane_arbiter.sv
// Randomized and directed checks of three lane_arbiter configurations against a
// transfer-level reference model.
module tb_lane_arbiter;
    localparam int N = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [N*4-1:0] req = '0;

    always #5 clk = ~clk;

    lane_arbiter_if #(.NODE_COUNT(8), .NODE_COUNT_DIGIT(3)) if0 ();
    lane_arbiter_if #(.NODE_COUNT(8), .NODE_COUNT_DIGIT(3)) if1 ();
    lane_arbiter_if #(.NODE_COUNT(8), .NODE_COUNT_DIGIT(3)) if2 ();
    assign if0.req_in = req;
    assign if1.req_in = req;
    assign if2.req_in = req;

    lane_arbiter #(.NODE_COUNT(8), .NODE_COUNT_DIGIT(3), .DIRECTION(0), .HOLD_CYCLES(1), .REQ_W(4))
        u0 (.clk(clk), .reset(reset), .bus(if0.slave));
    lane_arbiter #(.NODE_COUNT(8), .NODE_COUNT_DIGIT(3), .DIRECTION(1), .HOLD_CYCLES(1), .REQ_W(4))
        u1 (.clk(clk), .reset(reset), .bus(if1.slave));
    lane_arbiter #(.NODE_COUNT(8), .NODE_COUNT_DIGIT(3), .DIRECTION(0), .HOLD_CYCLES(3), .REQ_W(4))
        u2 (.clk(clk), .reset(reset), .bus(if2.slave));

    logic [23:0] ctrl_w [3];
    logic [15:0] cnt_w  [3];
    logic [2:0]  src_w  [3];
    logic [2:0]  dst_w  [3];
    assign ctrl_w[0] = if0.ctrl_out;  assign cnt_w[0] = if0.xfer_count;
    assign ctrl_w[1] = if1.ctrl_out;  assign cnt_w[1] = if1.xfer_count;
    assign ctrl_w[2] = if2.ctrl_out;  assign cnt_w[2] = if2.xfer_count;
    assign src_w[0]  = if0.cur_src;   assign dst_w[0]  = if0.cur_dst;
    assign src_w[1]  = if1.cur_src;   assign dst_w[1]  = if1.cur_dst;
    assign src_w[2]  = if2.cur_src;   assign dst_w[2]  = if2.cur_dst;

    int dirs  [3] = '{0, 1, 0};
    int holds [3] = '{1, 1, 3};

    // Model: cycles of lane occupancy left (hold + turnaround), owner and rotation.
    int m_left [3];
    int m_src  [3];
    int m_dst  [3];
    int m_ptr  [3];
    int m_cnt  [3];

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Eligible requester with the smallest rotational distance from ptr, or -1.
    function automatic int winner(input int dir, input logic [N*4-1:0] r, input int ptr);
        int best, best_dist, d;
        best = -1;
        best_dist = N;
        for (int i = 0; i < N; i++) begin
            d = r[i*4 +: 3];
            if (r[i*4+3] && ((dir == 0) ? (d > i) : (d < i))) begin
                if (((i - ptr + N) % N) < best_dist) begin
                    best_dist = (i - ptr + N) % N;
                    best = i;
                end
            end
        end
        return best;
    endfunction

    function automatic logic [23:0] exp_ctrl(input int u);
        logic [23:0] e;
        e = '0;
        if (m_left[u] >= 2)
            for (int i = 0; i < N; i++) begin
                e[i*3]     = 1'b1;
                e[i*3 + 1] = (i == m_dst[u]);
                e[i*3 + 2] = (i == m_src[u]);
            end
        return e;
    endfunction

    task automatic model_reset();
        for (int u = 0; u < 3; u++) begin
            m_left[u] = 0; m_src[u] = 0; m_dst[u] = 0; m_ptr[u] = 0; m_cnt[u] = 0;
        end
    endtask

    task automatic model_edge(input int u);
        int w;
        if (m_left[u] == 0) begin
            w = winner(dirs[u], req, m_ptr[u]);
            if (w >= 0) begin
                m_src[u]  = w;
                m_dst[u]  = int'(req[w*4 +: 3]);
                m_left[u] = holds[u] + 1;
            end
        end else begin
            m_left[u]--;
            if (m_left[u] == 1) begin
                m_cnt[u] = (m_cnt[u] + 1) % 65536;
                m_ptr[u] = (m_src[u] + 1) % N;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int u = 0; u < 3; u++) begin
            model_edge(u);
            check($sformatf("u%0d_ctrl", u), 64'(ctrl_w[u]), 64'(exp_ctrl(u)));
            check($sformatf("u%0d_count", u), 64'(cnt_w[u]), 64'(m_cnt[u]));
            if (m_left[u] >= 2) begin
                check($sformatf("u%0d_src", u), 64'(src_w[u]), 64'(m_src[u]));
                check($sformatf("u%0d_dst", u), 64'(dst_w[u]), 64'(m_dst[u]));
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        req = '0;
        model_reset();
        #2;
        for (int u = 0; u < 3; u++) begin
            check($sformatf("u%0d_rst_ctrl", u), 64'(ctrl_w[u]), 64'd0);
            check($sformatf("u%0d_rst_count", u), 64'(cnt_w[u]), 64'd0);
            check($sformatf("u%0d_rst_src", u), 64'(src_w[u]), 64'd0);
            check($sformatf("u%0d_rst_dst", u), 64'(dst_w[u]), 64'd0);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    function automatic logic [N*4-1:0] one_req(input int node, input int dest);
        logic [N*4-1:0] r;
        r = '0;
        r[node*4 +: 4] = {1'b1, 3'(dest)};
        return r;
    endfunction

    initial begin
        int order [$];
        int expected_order [8] = '{0, 1, 2, 3, 4, 5, 6, 0};
        logic [23:0] prev;
        int glen;

        do_reset();

        // Idle lane stays quiet.
        repeat (10) step();

        // Single transfer 2 -> 5.
        req = one_req(2, 5);
        step();
        check("dir0_grant_node2", 64'(ctrl_w[0][2*3 +: 3]), 64'b101);
        check("dir0_rx_node5", 64'(ctrl_w[0][5*3 +: 3]), 64'b011);
        req = '0;
        step();
        check("dir0_release", 64'(ctrl_w[0]), 64'd0);
        check("dir0_one_xfer", 64'(cnt_w[0]), 64'd1);
        repeat (6) step();

        // All of 0..6 continuously request 7: strict rotation.
        do_reset();
        for (int i = 0; i < 7; i++) req[i*4 +: 4] = {1'b1, 3'd7};
        prev = '0;
        for (int c = 0; c < 40; c++) begin
            step();
            for (int i = 0; i < N; i++)
                if (ctrl_w[0][i*3 + 2] && !prev[i*3 + 2]) order.push_back(i);
            prev = ctrl_w[0];
        end
        check("rotation_len", 64'(order.size() >= 8), 64'd1);
        for (int k = 0; k < 8; k++)
            if (k < order.size())
                check($sformatf("rotation_%0d", k), 64'(order[k]), 64'(expected_order[k]));

        // Wrong-direction and self-addressed requests.
        do_reset();
        req = one_req(4, 1) | one_req(3, 3);
        repeat (20) step();
        check("dir0_wrong_dir_none", 64'(cnt_w[0]), 64'd0);
        check("dir1_granted", 64'(cnt_w[1] != 16'd0), 64'd1);
        check("hold3_wrong_dir_none", 64'(cnt_w[2]), 64'd0);

        // Long hold with the request withdrawn after the first grant cycle.
        do_reset();
        req = one_req(0, 6);
        step();
        req = '0;
        glen = 0;
        if (ctrl_w[2][2]) glen++;
        for (int c = 0; c < 8; c++) begin
            step();
            if (ctrl_w[2][2]) glen++;
        end
        check("hold3_grant_cycles", 64'(glen), 64'd3);

        // Reset in the second hold cycle.
        do_reset();
        req = one_req(0, 6) | one_req(4, 6);
        step();
        step();
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check("midxfer_ctrl_zero", 64'(ctrl_w[2]), 64'd0);
        check("midxfer_count_zero", 64'(cnt_w[2]), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        req = '0;
        for (int i = 0; i < 7; i++) req[i*4 +: 4] = {1'b1, 3'd7};
        step();
        check("restart_from_node0", 64'(ctrl_w[0][2]), 64'd1);
        repeat (5) step();

        // Random traffic.
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 3) == 0)
                for (int i = 0; i < N; i++)
                    req[i*4 +: 4] = {($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7))};
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
